fft_result_streamer: RTL
========================

// Module: fft_result_streamer
// PURPOSE
//  AXI4-Stream master that unloads a finished FFT frame from the result RAM onto m_axis_data_*.
//  Sits between the FFT controller (start/done handshake) and the downstream sink.
//  Hides the RAM read latency with a small prefetch FIFO, so full throughput survives arbitrary tready backpressure.
//  Supports optional bit-reversed read order for frames stored in digit-reversed layout.
// PARAMETERS
//  TRANSFORM_LENGTH  64  frame length N; power of two, >=4. AW = clogb2(N).
//  DATA_WIDTH        32  complex sample width (re|im packed).
//  RD_LATENCY         1  RAM read latency in cycles; legal values 1..3.
//  REORDER            0  0: ram_addr = k; 1: ram_addr = bit-reverse of k over AW bits.
// PORTS
//  aclk                input   1           clock
//  aresetn             input   1           reset; asynchronous, active-low
//  start               input   1           1-cycle pulse from controller: frame ready in RAM
//  busy                output  1           high from accepted start until done
//  done                output  1           1-cycle pulse after the tlast beat is accepted
//  ram_en              output  1           result RAM read enable
//  ram_addr            output  AW          result RAM read address
//  ram_rdata           input   DATA_WIDTH  read data; valid RD_LATENCY cycles after ram_en
//  m_axis_data_tdata   output  DATA_WIDTH  output sample
//  m_axis_data_tuser   output  AW          natural-order output index k of the current beat
//  m_axis_data_tvalid  output  1           beat valid
//  m_axis_data_tready  input   1           sink ready
//  m_axis_data_tlast   output  1           high on beat k = N-1 only
// BEHAVIOUR
//  Reset (async): busy=0, done=0, ram_en=0, ram_addr=0, tvalid=0, tlast=0, tdata=0, tuser=0.
//   Reset also empties the FIFO, zeroes all counters and discards in-flight reads.
//   Reset mid-frame aborts the frame: no done pulse, and no stale beat after release.
//  FSM: IDLE -> STREAM (start && !busy) -> DRAIN (last read issued) -> IDLE (tlast handshake).
//   The done pulse is generated on the IDLE transition.
//   start is ignored outside IDLE.
//  Read issue: rd_cnt counts 0..N-1.
//   ram_en=1 in a cycle iff state==STREAM && fifo_count + inflight < FIFO_DEPTH.
//   FIFO_DEPTH = RD_LATENCY+2.
//   Each issue takes ram_addr = f(rd_cnt) and then increments rd_cnt. No read is issued past k=N-1.
//  Return path: a RD_LATENCY-deep valid shift register tags each returning ram_rdata.
//   Tagged data is pushed into the FIFO together with its index k.
//   The FIFO never overflows, because credit is counted at issue time.
//  Output: tvalid = FIFO non-empty. tdata/tuser/tlast come from the FIFO head.
//   Pop on tvalid && tready.
//   tdata, tuser and tlast are held stable while tvalid && !tready (AXI rule).
//   tvalid never drops without a handshake.
//  Latency: first tvalid rises on the (RD_LATENCY+1)th rising edge after the edge that sampled start.
//  Throughput: with tready held 1, beats k=0..N-1 go out on N consecutive cycles with no bubbles.
//  Simultaneous push and pop with the FIFO full is legal; count is unchanged.
//   Credit is released on pop in the same cycle.
//  Counter wrap: rd_cnt and the output index are AW bits wide; both are cleared on return to IDLE.
//  done asserts exactly one cycle, on the edge after the tlast handshake. busy falls on that same edge.
//   A start in the done cycle is accepted (state is IDLE by then).
// TESTING
//  1. N=64, RD_LATENCY=1, REORDER=0, RAM[i]=i, tready=1, start pulse
//     -> tvalid high 2 edges later; tdata 0..63 on 64 consecutive cycles;
//     -> tlast only with tdata=63; done pulse 1 cycle later.
//  2. Same, REORDER=1 -> ram_addr sequence 0,32,16,48,8,...; tuser 0..63 in order; tdata = RAM[bitrev(tuser)].
//  3. tready random 30% duty, RD_LATENCY=3
//     -> all 64 beats delivered once, in order; tdata stable across stalls; FIFO count never exceeds 5.
//  4. tready=0 for 20 cycles after start -> exactly FIFO_DEPTH reads issued, then ram_en=0;
//     -> on release, stream resumes with no gap or loss.
//  5. aresetn pulled low at beat 17
//     -> all outputs go to 0 immediately; no done; a new start yields a clean frame with tuser 0..63.
//  6. start pulsed while busy and again in the done cycle
//     -> first extra start ignored; second starts a new frame with tvalid 2 edges later.

Source files
------------

// File: rtl/fft_result_streamer_if.sv
// AXI4-Stream bundle carrying FFT result beats from the streamer to the downstream sink.
// tuser carries the natural-order sample index k of the beat.
interface fft_result_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 6
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [AW-1:0]         tuser;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/fft_result_streamer.sv
// FFT result streamer: unloads a finished frame from the result RAM onto an AXI4-Stream master.
// Reads are issued against a credit count (FIFO occupancy + reads in flight), so the small
// prefetch FIFO can never overflow and full throughput is kept under any tready pattern.
// Optional bit-reversed addressing serves frames stored in digit-reversed order.
module fft_result_streamer #(
    parameter int TRANSFORM_LENGTH = 64,
    parameter int DATA_WIDTH       = 32,
    parameter int RD_LATENCY       = 1,
    parameter int REORDER          = 0,
    localparam int AW              = $clog2(TRANSFORM_LENGTH)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ram_en,
    output logic [AW-1:0]         o_ram_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    fft_result_streamer_if.master m_axis_data
);

    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int SW         = CW + 1;
    localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [AW-1:0]         r_rd_cnt;
    logic [RD_LATENCY-1:0] r_rd_vld;
    logic [AW-1:0]         r_rd_idx [RD_LATENCY];
    logic [CW-1:0]         r_inflight;

    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0]         r_fifo_idx  [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_fifo_count;

    logic                  r_done;

    logic [SW-1:0]         w_credit;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_push;
    logic [AW-1:0]         w_push_idx;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [AW-1:0]         w_head_idx;
    logic                  w_head_last;
    logic                  w_tlast_hs;

    function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit check, return-path tagging and output handshake decode.
    always_comb begin
        w_credit     = SW'(r_fifo_count) + SW'(r_inflight);
        w_issue      = (r_state == S_STREAM) && (w_credit < SW'(FIFO_DEPTH));
        w_last_issue = w_issue && (r_rd_cnt == AW'(TRANSFORM_LENGTH - 1));
        w_push       = r_rd_vld[RD_LATENCY-1];
        w_push_idx   = r_rd_idx[RD_LATENCY-1];
        w_fifo_empty = (r_fifo_count == '0);
        w_head_idx   = r_fifo_idx[r_rd_ptr];
        w_head_last  = (w_head_idx == AW'(TRANSFORM_LENGTH - 1));
        w_pop        = !w_fifo_empty && m_axis_data.tready;
        w_tlast_hs   = w_pop && w_head_last;
    end

    // Next-state logic: stream until the last read is issued, then drain until tlast is taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_tlast_hs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register and the one-cycle done pulse raised on the return to IDLE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_DRAIN) && w_tlast_hs;
        end
    end

    // Read counter: advances on every issued read and is cleared whenever the block is idle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_rd_cnt <= '0;
        end else if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + AW'(1);
        end
    end

    // Valid/index shift register that marks which cycle's RAM data belongs to an issued read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_rd_idx[i] <= '0;
            end
            r_inflight <= '0;
        end else begin
            r_rd_vld[0] <= w_issue;
            r_rd_idx[0] <= r_rd_cnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
                r_rd_idx[i] <= r_rd_idx[i-1];
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            r_fifo_count <= r_fifo_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage; contents are only meaningful under a non-zero count, so no reset is needed.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= i_ram_rdata;
            r_fifo_idx[r_wr_ptr]  <= w_push_idx;
        end
    end

    // Output drive: RAM port from the read counter, stream beat from the FIFO head (zero when empty).
    always_comb begin
        o_busy             = (r_state != S_IDLE);
        o_done             = r_done;
        o_ram_en           = w_issue;
        o_ram_addr         = (REORDER != 0) ? f_bitrev(r_rd_cnt) : r_rd_cnt;
        m_axis_data.tvalid = !w_fifo_empty;
        m_axis_data.tdata  = w_fifo_empty ? '0 : r_fifo_data[r_rd_ptr];
        m_axis_data.tuser  = w_fifo_empty ? '0 : w_head_idx;
        m_axis_data.tlast  = !w_fifo_empty && w_head_last;
    end

endmodule
